// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the 16-bit accumulator CPU. It holds the bus-mux
// selector codes (shared with the bus mux), the ALU operation codes, the
// memory-reference opcodes, the instruction-field positions and the
// controller state type.
// No ports: this file is a package only.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int BITS      = 16;
  localparam int ADDR_BITS = 12;

  // Bus-mux selector codes
  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_AR   = 3'd1;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_DR   = 3'd3;
  localparam logic [2:0] SEL_AC   = 3'd4;
  localparam logic [2:0] SEL_IR   = 3'd5;
  localparam logic [2:0] SEL_TR   = 3'd6;
  localparam logic [2:0] SEL_MEM  = 3'd7;

  // ALU operation codes. These are only meaningful while ac_ld is high.
  localparam logic [1:0] ALU_NONE = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_ADD  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  // Opcodes, taken from ir[14:12]
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RIO = 3'd7;  // register-reference / I/O

  // Instruction field positions
  localparam int HLT_BIT = 0;
  localparam int I_BIT   = 15;

  // Highest legal sequence count (T6)
  localparam logic [3:0] SC_MAX = 4'd6;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sequence_counter.sv
// ---------------------------------------------------------------------------
// sequence_counter
// This is the 4-bit timing counter (T0..T15) of the control unit. A clear
// has priority over an increment. The counter holds its value when neither
// strobe is set.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   i_clr  in   synchronous clear
//   i_inc  in   synchronous increment
//   o_sc   out  current count
// ---------------------------------------------------------------------------
module sequence_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_sc
);

  logic [3:0] r_sc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc <= 4'd0;
    end else if (i_clr) begin
      r_sc <= 4'd0;
    end else if (i_inc) begin
      r_sc <= r_sc + 4'd1;
    end
  end

  assign o_sc = r_sc;

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// This is the hardwired control unit for the 16-bit accumulator CPU. It steps
// through fetch (T0-T2), decode/indirect (T3) and execute (T4-T6). It drives
// the bus-mux selector and the datapath strobes. Every output is a
// combinational decode of the registered state, sequence count and latched
// instruction fields. The only exception is that dr_zero gates pc_inc at T6.
// An asynchronous reset therefore drops every strobe at once.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             level; leaves HALT and begins a fetch
//   ir                instruction register (I, opcode, HLT bit)
//   dr_zero           DR == 0 from the datapath (sampled only at T6)
//   bus_sel           bus-mux selector
//   ar_ld ... mem_wr  datapath strobes, applied at the next rising edge
//   alu_op            ALU operation, qualified by ac_ld
//   rr_exec           register-reference execute strobe
//   sc                current sequence count
//   halted            controller is in HALT
// ---------------------------------------------------------------------------
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int Bits = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [Bits-1:0] ir,
  input  logic            dr_zero,
  output logic [2:0]      bus_sel,
  output logic            ar_ld,
  output logic            ar_inc,
  output logic            pc_ld,
  output logic            pc_inc,
  output logic            dr_ld,
  output logic            dr_inc,
  output logic            ir_ld,
  output logic            ac_ld,
  output logic            mem_wr,
  output logic [1:0]      alu_op,
  output logic            rr_exec,
  output logic [3:0]      sc,
  output logic            halted
);

  state_t     r_state;
  logic       r_ind;     // latched I bit
  logic [2:0] r_op;      // latched opcode
  logic       r_hlt;     // latched HLT bit, so later ir changes are ignored

  logic [3:0] w_sc;
  logic       w_sc_clr;
  logic       w_sc_inc;
  logic       w_go_halt;
  logic       w_latch;

  // The address field and the unused register-reference bits do not
  // take part in sequencing.
  logic w_unused_ir_bits;
  assign w_unused_ir_bits = ^ir[Bits-5:HLT_BIT+1];

  sequence_counter u_sc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_sc_clr),
    .i_inc (w_sc_inc),
    .o_sc  (w_sc)
  );

  // The HALT/RUN flop and the instruction fields latched at the end of T2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HALT;
      r_ind   <= 1'b0;
      r_op    <= OP_AND;
      r_hlt   <= 1'b0;
    end else begin
      case (r_state)
        ST_HALT: if (start)     r_state <= ST_RUN;
        ST_RUN:  if (w_go_halt) r_state <= ST_HALT;
        default:                r_state <= ST_HALT;
      endcase
      if (w_latch) begin
        r_ind <= ir[Bits-1];
        r_op  <= ir[Bits-2:Bits-4];
        r_hlt <= ir[HLT_BIT];
      end
    end
  end

  // Decode of (state, sc, latched I/opcode) into strobes and sequencing.
  always_comb begin
    bus_sel   = SEL_NONE;
    ar_ld     = 1'b0;
    ar_inc    = 1'b0;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    dr_ld     = 1'b0;
    dr_inc    = 1'b0;
    ir_ld     = 1'b0;
    ac_ld     = 1'b0;
    mem_wr    = 1'b0;
    alu_op    = ALU_NONE;
    rr_exec   = 1'b0;
    w_sc_clr  = 1'b0;
    w_sc_inc  = 1'b0;
    w_go_halt = 1'b0;
    w_latch   = 1'b0;

    if (r_state != ST_RUN) begin
      // Keep the count at 0 so that a restart always begins at T0.
      w_sc_clr = 1'b1;
    end else begin
      case (w_sc)
        4'd0: begin
          bus_sel  = SEL_PC;
          ar_ld    = 1'b1;
          w_sc_inc = 1'b1;
        end
        4'd1: begin
          bus_sel  = SEL_MEM;
          ir_ld    = 1'b1;
          pc_inc   = 1'b1;
          w_sc_inc = 1'b1;
        end
        4'd2: begin
          bus_sel  = SEL_IR;
          ar_ld    = 1'b1;
          w_latch  = 1'b1;
          w_sc_inc = 1'b1;
        end
        4'd3: begin
          if (r_op == OP_RIO) begin
            w_sc_clr = 1'b1;
            if (!r_ind) begin
              rr_exec   = 1'b1;
              w_go_halt = r_hlt;
            end
          end else begin
            if (r_ind) begin
              bus_sel = SEL_MEM;
              ar_ld   = 1'b1;
            end
            w_sc_inc = 1'b1;
          end
        end
        4'd4: begin
          case (r_op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_sel  = SEL_MEM;
              dr_ld    = 1'b1;
              w_sc_inc = 1'b1;
            end
            OP_STA: begin
              bus_sel  = SEL_AC;
              mem_wr   = 1'b1;
              w_sc_clr = 1'b1;
            end
            OP_BUN: begin
              bus_sel  = SEL_AR;
              pc_ld    = 1'b1;
              w_sc_clr = 1'b1;
            end
            OP_BSA: begin
              bus_sel  = SEL_PC;
              mem_wr   = 1'b1;
              ar_inc   = 1'b1;
              w_sc_inc = 1'b1;
            end
            default: begin
              w_sc_clr  = 1'b1;
              w_go_halt = 1'b1;
            end
          endcase
        end
        4'd5: begin
          case (r_op)
            OP_AND: begin
              ac_ld    = 1'b1;
              alu_op   = ALU_AND;
              w_sc_clr = 1'b1;
            end
            OP_ADD: begin
              ac_ld    = 1'b1;
              alu_op   = ALU_ADD;
              w_sc_clr = 1'b1;
            end
            OP_LDA: begin
              ac_ld    = 1'b1;
              alu_op   = ALU_PASS;
              w_sc_clr = 1'b1;
            end
            OP_BSA: begin
              bus_sel  = SEL_AR;
              pc_ld    = 1'b1;
              w_sc_clr = 1'b1;
            end
            OP_ISZ: begin
              dr_inc   = 1'b1;
              w_sc_inc = 1'b1;
            end
            default: begin
              w_sc_clr  = 1'b1;
              w_go_halt = 1'b1;
            end
          endcase
        end
        SC_MAX: begin
          if (r_op == OP_ISZ) begin
            bus_sel  = SEL_DR;
            mem_wr   = 1'b1;
            pc_inc   = dr_zero;  // skip the next instruction when DR wrapped to 0
            w_sc_clr = 1'b1;
          end else begin
            w_sc_clr  = 1'b1;
            w_go_halt = 1'b1;
          end
        end
        default: begin
          // Counts 7-15 cannot be reached. Recover to HALT with every output held at 0.
          w_sc_clr  = 1'b1;
          w_go_halt = 1'b1;
        end
      endcase
    end
  end

  assign sc     = w_sc;
  assign halted = (r_state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Directed testbench. Each test pushes the expected per-cycle output vector
// onto a queue and then pops one entry per cycle to compare against the DUT.
// Vector layout: {halted, sc[3:0], bus_sel[2:0], ar_ld, ar_inc, pc_ld, pc_inc,
//                 dr_ld, dr_inc, ir_ld, ac_ld, mem_wr, alu_op[1:0], rr_exec}
// ---------------------------------------------------------------------------
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] ir;
  logic        dr_zero;
  logic [2:0]  bus_sel;
  logic        ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ir_ld, ac_ld, mem_wr;
  logic [1:0]  alu_op;
  logic        rr_exec;
  logic [3:0]  sc;
  logic        halted;

  control_sequencer #(.Bits(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ir      (ir),
    .dr_zero (dr_zero),
    .bus_sel (bus_sel),
    .ar_ld   (ar_ld),
    .ar_inc  (ar_inc),
    .pc_ld   (pc_ld),
    .pc_inc  (pc_inc),
    .dr_ld   (dr_ld),
    .dr_inc  (dr_inc),
    .ir_ld   (ir_ld),
    .ac_ld   (ac_ld),
    .mem_wr  (mem_wr),
    .alu_op  (alu_op),
    .rr_exec (rr_exec),
    .sc      (sc),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {halted, sc, bus_sel, ar_ld, ar_inc, pc_ld, pc_inc,
                dr_ld, dr_inc, ir_ld, ac_ld, mem_wr, alu_op, rr_exec};

  // Strobe masks in vector order
  localparam logic [8:0] ARL = 9'b1_0000_0000;
  localparam logic [8:0] ARI = 9'b0_1000_0000;
  localparam logic [8:0] PCL = 9'b0_0100_0000;
  localparam logic [8:0] PCI = 9'b0_0010_0000;
  localparam logic [8:0] DRL = 9'b0_0001_0000;
  localparam logic [8:0] DRI = 9'b0_0000_1000;
  localparam logic [8:0] IRL = 9'b0_0000_0100;
  localparam logic [8:0] ACL = 9'b0_0000_0010;
  localparam logic [8:0] MW  = 9'b0_0000_0001;
  localparam logic [8:0] NO  = 9'b0_0000_0000;

  typedef struct {
    string       tag;
    logic [19:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [19:0] vec(input logic h, input logic [3:0] s,
                                      input logic [2:0] b, input logic [8:0] st,
                                      input logic [1:0] a, input logic rr);
    return {h, s, b, st, a, rr};
  endfunction

  function automatic logic [19:0] halt_v();
    return vec(1'b1, 4'd0, 3'd0, NO, 2'd0, 1'b0);
  endfunction

  task automatic expect_v(input string tag, input logic [19:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic push_fetch(input string n);
    expect_v({n, "_T0"}, vec(1'b0, 4'd0, 3'd2, ARL,       2'd0, 1'b0));
    expect_v({n, "_T1"}, vec(1'b0, 4'd1, 3'd7, IRL | PCI, 2'd0, 1'b0));
    expect_v({n, "_T2"}, vec(1'b0, 4'd2, 3'd5, ARL,       2'd0, 1'b0));
  endtask

  task automatic check_now();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
      $display("check %-10s sc=%0d bus=%0d obs=%h exp=%h", e.tag, sc, bus_sel, obs, e.v);
    end
  endtask

  task automatic check_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_now();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    ir      = 16'h0000;
    dr_zero = 1'b0;

    // Reset state
    expect_v("reset", halt_v());
    check_n(1);
    rst_n = 1'b1;
    expect_v("idle", halt_v());
    check_n(1);

    // HLT (register-reference with HLT bit), start held high throughout
    start = 1'b1;
    ir    = 16'h7001;
    push_fetch("hlt");
    expect_v("hlt_T3", vec(1'b0, 4'd3, 3'd0, NO, 2'd0, 1'b1));
    check_n(4);
    expect_v("hlt_halt", halt_v());
    check_n(1);

    // ADD direct; restarts after exactly one HALT cycle because start is still high
    ir = 16'h1123;
    push_fetch("add");
    check_n(1);
    start = 1'b0;
    check_n(2);
    expect_v("add_T3", vec(1'b0, 4'd3, 3'd0, NO, 2'd0, 1'b0));
    check_n(1);
    ir = 16'hA050;  // change after T2 must not disturb ADD
    expect_v("add_T4", vec(1'b0, 4'd4, 3'd7, DRL, 2'd0, 1'b0));
    expect_v("add_T5", vec(1'b0, 4'd5, 3'd0, ACL, 2'd2, 1'b0));
    check_n(2);

    // LDA indirect
    push_fetch("lda");
    expect_v("lda_T3", vec(1'b0, 4'd3, 3'd7, ARL, 2'd0, 1'b0));
    check_n(4);
    ir = 16'h6010;
    expect_v("lda_T4", vec(1'b0, 4'd4, 3'd7, DRL, 2'd0, 1'b0));
    expect_v("lda_T5", vec(1'b0, 4'd5, 3'd0, ACL, 2'd3, 1'b0));
    check_n(2);

    // ISZ with dr_zero=1 at T6 (also high during T5, where it must not matter)
    push_fetch("isz1");
    expect_v("isz1_T3", vec(1'b0, 4'd3, 3'd0, NO,  2'd0, 1'b0));
    expect_v("isz1_T4", vec(1'b0, 4'd4, 3'd7, DRL, 2'd0, 1'b0));
    check_n(5);
    dr_zero = 1'b1;
    expect_v("isz1_T5", vec(1'b0, 4'd5, 3'd0, DRI, 2'd0, 1'b0));
    check_n(1);
    expect_v("isz1_T6", vec(1'b0, 4'd6, 3'd3, MW | PCI, 2'd0, 1'b0));
    check_n(1);
    dr_zero = 1'b0;

    // ISZ again with dr_zero=0
    push_fetch("isz0");
    expect_v("isz0_T3", vec(1'b0, 4'd3, 3'd0, NO, 2'd0, 1'b0));
    check_n(4);
    ir = 16'h5200;
    expect_v("isz0_T4", vec(1'b0, 4'd4, 3'd7, DRL, 2'd0, 1'b0));
    expect_v("isz0_T5", vec(1'b0, 4'd5, 3'd0, DRI, 2'd0, 1'b0));
    expect_v("isz0_T6", vec(1'b0, 4'd6, 3'd3, MW,  2'd0, 1'b0));
    check_n(3);

    // BSA
    push_fetch("bsa");
    expect_v("bsa_T3", vec(1'b0, 4'd3, 3'd0, NO, 2'd0, 1'b0));
    check_n(4);
    ir = 16'h3040;
    expect_v("bsa_T4", vec(1'b0, 4'd4, 3'd2, MW | ARI, 2'd0, 1'b0));
    expect_v("bsa_T5", vec(1'b0, 4'd5, 3'd1, PCL,      2'd0, 1'b0));
    check_n(2);

    // STA, with reset asserted in the middle of T4
    push_fetch("sta");
    expect_v("sta_T3", vec(1'b0, 4'd3, 3'd0, NO, 2'd0, 1'b0));
    expect_v("sta_T4", vec(1'b0, 4'd4, 3'd4, MW, 2'd0, 1'b0));
    check_n(5);
    #2 rst_n = 1'b0;
    #1;
    expect_v("sta_rst", halt_v());
    check_now();
    @(negedge clk);
    rst_n = 1'b1;
    expect_v("post_rst0", halt_v());
    expect_v("post_rst1", halt_v());
    expect_v("post_rst2", halt_v());
    check_n(3);

    // BUN followed immediately by a HLT instruction
    start = 1'b1;
    ir    = 16'h4010;
    push_fetch("bun");
    check_n(1);
    start = 1'b0;
    expect_v("bun_T3", vec(1'b0, 4'd3, 3'd0, NO, 2'd0, 1'b0));
    check_n(3);
    ir = 16'h7001;
    expect_v("bun_T4", vec(1'b0, 4'd4, 3'd1, PCL, 2'd0, 1'b0));
    push_fetch("hlt2");
    expect_v("hlt2_T3", vec(1'b0, 4'd3, 3'd0, NO, 2'd0, 1'b1));
    expect_v("hlt2_h0", halt_v());
    expect_v("hlt2_h1", halt_v());
    check_n(7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 16-bit accumulator CPU. It runs the fetch, decode, indirect and execute sequence through a 4-bit sequence counter (T0–T6). Each cycle it drives the bus-mux selector and the register load, increment and memory-write strobes of the datapath. It executes all memory-reference instructions, issues a register-reference execute strobe, and stops on HLT.

## Interface
- `Bits`, 16, datapath word width; `ir` is Bits wide, address field is fixed at 12 bits.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level; leave HALT and begin fetch
- `ir`  in  Bits  instruction register contents: ir[15]=I, ir[14:12]=opcode, ir[0]=HLT bit
- `dr_zero`  in  1  DR == 0, from datapath
- `bus_sel`  out  3  bus-mux selector: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
- `ar_ld`, `ar_inc`, `pc_ld`, `pc_inc`, `dr_ld`, `dr_inc`, `ir_ld`, `ac_ld`, `mem_wr`  out  1 each  datapath strobes, applied at the next rising edge
- `alu_op`  out  2  0 none, 1 AND, 2 ADD, 3 pass DR; qualified by `ac_ld`
- `rr_exec`  out  1  one-cycle register-reference execute strobe
- `sc`  out  4  current sequence count
- `halted`  out  1  controller is in HALT

## Operation
- States: HALT and RUN. RUN is indexed by `sc`.
- In HALT, `start` is sampled each cycle. If it is 1, the next state is RUN with T0. `start` is ignored in RUN.
- Fetch sequence:
  - T0: `bus_sel`=2, `ar_ld`.
  - T1: `bus_sel`=7, `ir_ld`, `pc_inc`.
  - T2: `bus_sel`=5, `ar_ld`. I and opcode are latched from `ir` at the end of T2.
- T3:
  - Opcode 7 with I=0: `rr_exec`. If ir[0]=1, go to HALT; otherwise clear SC.
  - Opcode 7 with I=1 (I/O): no strobes; clear SC.
  - Other opcodes with I=1: `bus_sel`=7, `ar_ld`.
  - Other opcodes with I=0: no strobes.
- AND (0), ADD (1), LDA (2):
  - T4: `bus_sel`=7, `dr_ld`.
  - T5: `ac_ld` with `alu_op` 1, 2 or 3 respectively; clear SC.
- STA (3):
  - T4: `bus_sel`=4, `mem_wr`; clear SC.
- BUN (4):
  - T4: `bus_sel`=1, `pc_ld`; clear SC.
- BSA (5):
  - T4: `bus_sel`=2, `mem_wr`, `ar_inc`.
  - T5: `bus_sel`=1, `pc_ld`; clear SC.
- ISZ (6):
  - T4: `bus_sel`=7, `dr_ld`.
  - T5: `dr_inc`.
  - T6: `bus_sel`=3, `mem_wr`, plus `pc_inc` if `dr_zero`=1; clear SC.
- "Clear SC" means the next cycle is T0 of the next instruction, with no idle cycle.
- Strobes not listed for a cycle are 0, and `bus_sel`=0. In HALT all strobes and `bus_sel` are 0.

## Timing
- `sc`, state, and the latched I/opcode are registers. All outputs are combinational decodes of these registers only; there is no input-to-output path except `dr_zero`→`pc_inc` at T6.
- Reset values: state=HALT, `sc`=0, I/opcode=0, `halted`=1, every other output 0.
- Instruction length from T0 to the next T0:
  - register-reference and I/O: 4 cycles
  - STA, BUN: 5 cycles
  - AND, ADD, LDA, BSA: 6 cycles
  - ISZ: 7 cycles
  - Indirect addressing adds no cycles.
- HLT: T3 is followed by HALT. At least one HALT cycle precedes any restart, even if `start` is held high.
- `sc` never exceeds 6. Unreachable counts (7–15) return to HALT with all outputs 0.
- `dr_zero` is sampled only in T6, where it reflects the value after the T5 increment.
- Reset asserted mid-instruction forces HALT and drops all strobes immediately (asynchronously), including `mem_wr`. The partial instruction is abandoned.
- `ir` changes outside T2 do not affect the current instruction.

## Structure
- Shared package `cpu_pkg` holds:
  - bus-selector constants (`SEL_NONE` … `SEL_MEM`, shared with the bus mux)
  - `alu_op` codes
  - opcode constants (`OP_AND` … `OP_ISZ`, `OP_RIO`)
  - `HLT_BIT` index
- Sub-module `sequence_counter`: 4-bit counter with synchronous clear and increment, asynchronous active-low reset.
- The remainder is a single decode block plus the HALT/RUN flop.

## Test plan
- Reset, then `start`=1, `ir`=16'h7001 → `bus_sel` 2,7,5,0 over T0–T3; `rr_exec`=1 at T3; `halted`=1 from the next cycle; all strobes 0 afterwards.
- ADD direct, `ir`=16'h1123 → `bus_sel` 2,7,5,0,7,0; T5 has `ac_ld`=1 and `alu_op`=2; the following cycle is `sc`=0.
- LDA indirect, `ir`=16'hA050 → T3 has `bus_sel`=7 and `ar_ld`=1; T5 has `alu_op`=3; total 6 cycles.
- ISZ, `ir`=16'h6010:
  - with `dr_zero`=1 at T6 → `bus_sel`=3, `mem_wr`=1, `pc_inc`=1
  - repeated with `dr_zero`=0 → `pc_inc`=0
- BSA, `ir`=16'h5200 → T4 has `bus_sel`=2, `mem_wr`, `ar_inc`; T5 has `bus_sel`=1, `pc_ld`.
- STA, `ir`=16'h3040, `rst_n` low in mid-T4 → `mem_wr` drops to 0 within the cycle, `halted`=1, `sc`=0; after release, no activity until `start`.
